// File: rtl/ram_dp_clr.sv
// Simple-dual-port synchronous RAM with one write port and one read port on a shared clock.
// Adds a registered read-valid flag, a selectable read-during-write policy and a clear
// sequencer that fills every word with INIT_VAL after reset or on request.
module ram_dp_clr #(
    parameter int unsigned   AW           = 3,
    parameter int unsigned   DW           = 4,
    parameter bit            BYPASS       = 1'b1,
    parameter bit            CLR_ON_RESET = 1'b1,
    parameter logic [DW-1:0] INIT_VAL     = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addrw,
    input  logic [AW-1:0] addrr,
    input  logic [1:0]    rw,
    input  logic [DW-1:0] data_in,
    input  logic          clear,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic          busy,
    output logic          drop
);

    localparam int unsigned Depth = 1 << AW;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem [Depth];

    logic          rd_en;
    logic          wr_en;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          bypass_hit;
    logic [DW-1:0] rd_data;

    assign busy = (state_q == StClear);

    // User accesses are only honoured outside the clear sequence.
    assign rd_en = ~busy & rw[0];
    assign wr_en = ~busy & rw[1];

    // The clear sequencer owns the write port while busy; nothing is written during reset.
    assign mem_we    = ~reset & (busy | wr_en);
    assign mem_waddr = busy ? cnt_q : addrw;
    assign mem_wdata = busy ? INIT_VAL : data_in;

    // Write-first forwarding for a same-address read and write in the same cycle.
    assign bypass_hit = BYPASS && wr_en && (addrw == addrr);
    assign rd_data    = bypass_hit ? data_in : mem[addrr];

    // Next-state logic for the clear sequencer; a clear request always restarts at word 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                if (clear) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = StIdle;
                    end
                end
            end
            StIdle: begin
                if (clear) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state and clear counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLR_ON_RESET ? StClear : StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port, valid flag and drop pulse for requests refused while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            drop      <= 1'b0;
        end else begin
            if (rd_en) begin
                data_out <= rd_data;
            end
            valid_out <= rd_en;
            drop      <= busy & (|rw);
        end
    end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: write-first, read-first and no-auto-clear instances
// driven in lockstep, with read results checked against a scoreboard queue.
module tb_ram_dp_clr;

    localparam int AW    = 3;
    localparam int DW    = 4;
    localparam int Depth = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addrw, addrr;
    logic [1:0]    rw;
    logic [DW-1:0] data_in;
    logic          clear;

    logic [DW-1:0] dout_wf, dout_rf, dout_nc;
    logic          vld_wf, vld_rf, vld_nc;
    logic          busy_wf, busy_rf, busy_nc;
    logic          drop_wf, drop_rf, drop_nc;

    always #5 clk = ~clk;

    ram_dp_clr #(.AW(AW), .DW(DW), .BYPASS(1'b1), .CLR_ON_RESET(1'b1), .INIT_VAL(4'h0)) dut (
        .clk(clk), .reset(reset), .addrw(addrw), .addrr(addrr), .rw(rw), .data_in(data_in),
        .clear(clear), .data_out(dout_wf), .valid_out(vld_wf), .busy(busy_wf), .drop(drop_wf)
    );

    ram_dp_clr #(.AW(AW), .DW(DW), .BYPASS(1'b0), .CLR_ON_RESET(1'b1), .INIT_VAL(4'h0)) dut_rf (
        .clk(clk), .reset(reset), .addrw(addrw), .addrr(addrr), .rw(rw), .data_in(data_in),
        .clear(clear), .data_out(dout_rf), .valid_out(vld_rf), .busy(busy_rf), .drop(drop_rf)
    );

    ram_dp_clr #(.AW(AW), .DW(DW), .BYPASS(1'b1), .CLR_ON_RESET(1'b0), .INIT_VAL(4'h5)) dut_nc (
        .clk(clk), .reset(reset), .addrw(addrw), .addrr(addrr), .rw(rw), .data_in(data_in),
        .clear(clear), .data_out(dout_nc), .valid_out(vld_nc), .busy(busy_nc), .drop(drop_nc)
    );

    typedef struct {
        logic [DW-1:0] wf;
        logic [DW-1:0] rf;
        logic [DW-1:0] nc;
        bit            chk_nc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m_mem [Depth];
    logic [DW-1:0] nc_mem [Depth];
    bit            nc_known [Depth];
    int            n_cmp = 0;
    int            n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one idle-state operation for a cycle; queue the expected read result.
    task automatic idle_op(input logic [1:0] op, input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                           input logic [DW-1:0] d, input logic clr);
        exp_t e;
        bit   same;
        rw = op; addrw = wa; addrr = ra; data_in = d; clear = clr;
        same = op[1] && (wa == ra);
        if (op[0]) begin
            e.wf     = same ? d : m_mem[ra];
            e.rf     = m_mem[ra];
            e.nc     = same ? d : nc_mem[ra];
            e.chk_nc = same || nc_known[ra];
            sb.push_back(e);
        end
        if (op[1]) begin
            m_mem[wa]    = d;
            nc_mem[wa]   = d;
            nc_known[wa] = 1'b1;
        end
        step();
        rw = 2'b00; clear = 1'b0;
    endtask

    task automatic model_cleared(input bit nc_too);
        for (int i = 0; i < Depth; i++) begin
            m_mem[i] = 4'h0;
            if (nc_too) begin
                nc_mem[i]   = 4'h5;
                nc_known[i] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        int s;
        exp_t e;
        reset = 1'b1; rw = 2'b00; addrw = '0; addrr = '0; data_in = '0; clear = 1'b0;
        step();
        step();
        n_cmp++;
        if (dout_wf !== 4'h0 || vld_wf !== 1'b0 || drop_wf !== 1'b0 || busy_wf !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: dout=%h vld=%b drop=%b busy=%b, want 0 0 0 1",
                     dout_wf, vld_wf, drop_wf, busy_wf);
        end
        n_cmp++;
        if (busy_nc !== 1'b0 || dout_nc !== 4'h0 || vld_nc !== 1'b0 || drop_nc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_noclr: busy=%b dout=%h vld=%b drop=%b, want 0 0 0 0",
                     busy_nc, dout_nc, vld_nc, drop_nc);
        end
        reset = 1'b0;
        s = 0;
        while (busy_wf === 1'b1 && s < 40) begin
            s++;
            step();
        end
        n_cmp++;
        if (s != 8 || busy_rf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clear_len: busy cycles=%0d rf_busy=%b, want 8 0", s, busy_rf);
        end
        model_cleared(1'b0);
        for (int a = 0; a < Depth; a++) begin
            idle_op(2'b01, '0, AW'(a), '0, 1'b0);
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL reset_read_sb: queue empty at addr %0d", a);
            end else begin
                e = sb.pop_front();
                if (vld_wf !== 1'b1 || dout_wf !== e.wf || vld_rf !== 1'b1 || dout_rf !== e.rf) begin
                    n_fail++;
                    $display("FAIL reset_read[%0d]: got %b/%h %b/%h, want 1/%h 1/%h", a,
                             vld_wf, dout_wf, vld_rf, dout_rf, e.wf, e.rf);
                end
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        idle_op(2'b10, 3'd3, '0, 4'hA, 1'b0);
        n_cmp++;
        if (vld_wf !== 1'b0 || vld_nc !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_only_valid: got %b %b, want 0 0", vld_wf, vld_nc);
        end
        idle_op(2'b01, '0, 3'd3, '0, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if (vld_wf !== 1'b1 || dout_wf !== 4'hA || dout_wf !== e.wf || dout_nc !== e.nc) begin
            n_fail++;
            $display("FAIL wr_rd_a: got vld=%b dout=%h nc=%h, want 1 %h %h",
                     vld_wf, dout_wf, dout_nc, e.wf, e.nc);
        end
        step();
        n_cmp++;
        if (vld_wf !== 1'b0 || dout_wf !== 4'hA || vld_rf !== 1'b0 || dout_rf !== 4'hA) begin
            n_fail++;
            $display("FAIL rd_hold: got %b/%h %b/%h, want 0/a 0/a", vld_wf, dout_wf, vld_rf, dout_rf);
        end
    endtask

    task automatic test_raw();
        exp_t e;
        idle_op(2'b10, 3'd5, '0, 4'h2, 1'b0);
        idle_op(2'b11, 3'd5, 3'd5, 4'h9, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if (dout_wf !== 4'h9 || dout_rf !== 4'h2 || dout_wf !== e.wf || dout_rf !== e.rf
            || vld_rf !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_same: wf=%h rf=%h vld_rf=%b, want 9 2 1", dout_wf, dout_rf, vld_rf);
        end
        idle_op(2'b01, '0, 3'd5, '0, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if (dout_wf !== e.wf || dout_rf !== e.rf || dout_rf !== 4'h9) begin
            n_fail++;
            $display("FAIL raw_later: wf=%h rf=%h, want %h %h", dout_wf, dout_rf, e.wf, e.rf);
        end
        idle_op(2'b11, 3'd6, 3'd5, 4'h7, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if (dout_wf !== e.wf || dout_rf !== e.rf) begin
            n_fail++;
            $display("FAIL raw_diff: wf=%h rf=%h, want %h %h", dout_wf, dout_rf, e.wf, e.rf);
        end
        idle_op(2'b01, '0, 3'd6, '0, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if (dout_wf !== 4'h7 || dout_rf !== e.rf) begin
            n_fail++;
            $display("FAIL raw_diff_rd: wf=%h rf=%h, want 7 %h", dout_wf, dout_rf, e.rf);
        end
    endtask

    task automatic test_back_to_back();
        exp_t          e;
        logic [1:0]    op;
        logic [AW-1:0] wa, ra;
        for (int i = 0; i < 32; i++) begin
            op = 2'($urandom_range(0, 3));
            wa = AW'($urandom_range(0, Depth - 1));
            ra = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, Depth - 1));
            idle_op(op, wa, ra, DW'($urandom_range(0, 15)), 1'b0);
            n_cmp++;
            if (op[0]) begin
                e = sb.pop_front();
                if (vld_wf !== 1'b1 || dout_wf !== e.wf || vld_rf !== 1'b1 || dout_rf !== e.rf
                    || vld_nc !== 1'b1 || (e.chk_nc && dout_nc !== e.nc)) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got %b/%h %b/%h nc %h, want 1/%h 1/%h nc %h", i,
                             vld_wf, dout_wf, vld_rf, dout_rf, dout_nc, e.wf, e.rf, e.nc);
                end
            end else if (vld_wf !== 1'b0 || vld_rf !== 1'b0 || vld_nc !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_novld[%0d]: got %b %b %b, want 0 0 0", i, vld_wf, vld_rf, vld_nc);
            end
        end
    endtask

    task automatic test_clear_drop();
        int s;
        exp_t e;
        idle_op(2'b00, '0, '0, '0, 1'b1);
        n_cmp++;
        if (busy_wf !== 1'b1 || busy_nc !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_start: busy=%b nc=%b, want 1 1", busy_wf, busy_nc);
        end
        rw = 2'b01; addrr = 3'd2;
        step();
        n_cmp++;
        if (drop_wf !== 1'b1 || drop_rf !== 1'b1 || vld_wf !== 1'b0 || vld_rf !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_rd: drop=%b vld=%b, want 1 0", drop_wf, vld_wf);
        end
        rw = 2'b10; addrw = 3'd4; data_in = 4'hE;
        step();
        n_cmp++;
        if (drop_wf !== 1'b1 || vld_wf !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_wr: drop=%b vld=%b, want 1 0", drop_wf, vld_wf);
        end
        rw = 2'b00;
        step();
        n_cmp++;
        if (drop_wf !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_pulse: drop=%b, want 0", drop_wf);
        end
        s = 3;
        while (busy_wf === 1'b1 && s < 40) begin
            s++;
            step();
        end
        n_cmp++;
        if (s != 8) begin
            n_fail++;
            $display("FAIL clr_len: busy cycles=%0d, want 8", s);
        end
        model_cleared(1'b1);
        for (int a = 0; a < Depth; a++) begin
            idle_op(2'b01, '0, AW'(a), '0, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (vld_wf !== 1'b1 || dout_wf !== e.wf || dout_rf !== e.rf || dout_nc !== e.nc) begin
                n_fail++;
                $display("FAIL clr_read[%0d]: got %h %h %h, want %h %h %h", a,
                         dout_wf, dout_rf, dout_nc, e.wf, e.rf, e.nc);
            end
        end
    endtask

    task automatic test_clear_restart();
        int s;
        exp_t e;
        for (int a = 0; a < Depth; a++) begin
            idle_op(2'b10, AW'(a), '0, 4'hF, 1'b0);
        end
        idle_op(2'b00, '0, '0, '0, 1'b1);
        // Second request is sampled at the end of the third busy cycle: 3 + 8 busy cycles.
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        s = 3;
        while (busy_wf === 1'b1 && s < 60) begin
            s++;
            step();
        end
        n_cmp++;
        if (s != 11) begin
            n_fail++;
            $display("FAIL restart_len: busy cycles=%0d, want 11", s);
        end
        model_cleared(1'b1);
        for (int a = 0; a < Depth; a++) begin
            idle_op(2'b01, '0, AW'(a), '0, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (vld_wf !== 1'b1 || dout_wf !== e.wf || dout_rf !== e.rf || dout_nc !== e.nc) begin
                n_fail++;
                $display("FAIL restart_read[%0d]: got %h %h %h, want %h %h %h", a,
                         dout_wf, dout_rf, dout_nc, e.wf, e.rf, e.nc);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int s;
        exp_t e;
        idle_op(2'b10, 3'd1, '0, 4'h7, 1'b0);
        // Read issued together with a clear request still completes.
        idle_op(2'b01, '0, 3'd1, '0, 1'b1);
        e = sb.pop_front();
        n_cmp++;
        if (vld_wf !== 1'b1 || dout_wf !== 4'h7 || dout_wf !== e.wf || busy_wf !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_with_clr: vld=%b dout=%h busy=%b, want 1 7 1", vld_wf, dout_wf, busy_wf);
        end
        for (int i = 0; i < 4; i++) begin
            step();
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (dout_wf !== 4'h0 || vld_wf !== 1'b0 || dout_rf !== 4'h0 || busy_wf !== 1'b1
            || busy_nc !== 1'b0 || dout_nc !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset: dout=%h vld=%b rf=%h busy=%b nc_busy=%b nc=%h, want 0 0 0 1 0 0",
                     dout_wf, vld_wf, dout_rf, busy_wf, busy_nc, dout_nc);
        end
        step();
        step();
        reset = 1'b0;
        s = 0;
        while (busy_wf === 1'b1 && s < 40) begin
            s++;
            step();
        end
        n_cmp++;
        if (s != 8) begin
            n_fail++;
            $display("FAIL mid_reset_len: busy cycles=%0d, want 8", s);
        end
        model_cleared(1'b0);
        for (int i = 0; i < Depth; i++) begin
            nc_known[i] = 1'b0;
        end
        for (int a = 0; a < Depth; a++) begin
            idle_op(2'b01, '0, AW'(a), '0, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (vld_wf !== 1'b1 || dout_wf !== e.wf || vld_rf !== 1'b1 || dout_rf !== e.rf) begin
                n_fail++;
                $display("FAIL mid_reset_read[%0d]: got %h %h, want %h %h", a,
                         dout_wf, dout_rf, e.wf, e.rf);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < Depth; i++) begin
            m_mem[i]    = 4'h0;
            nc_mem[i]   = 4'h0;
            nc_known[i] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_raw();
        test_back_to_back();
        test_clear_drop();
        test_clear_restart();
        test_reset_mid_clear();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop in case a wait ever fails to return.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
